i2c_poll_sequencer: RTL and testbench

//  Multi-channel successor to the single-nunchuck driver FSM. Sequences init writes,

---
 rtl/i2c_poll_sequencer_if.sv | 32 +++
 rtl/i2c_poll_sequencer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_i2c_poll_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_poll_sequencer_if.sv
// Command/response bus between the poll sequencer and the shared low-level I2C engine.
// Handshake: the sequencer raises ll_start for exactly one cycle with ll_write, ll_dev,
// ll_reg, ll_wdata and ll_len valid, and holds those fields stable until the engine
// answers. The engine answers with a one-cycle ll_done; ll_nack and ll_rdata are valid
// only in that ll_done cycle. ll_enable is low whenever the sequencer is idle.
interface i2c_poll_sequencer_if #(
  parameter int MAX_BYTES = 6,
  parameter int LW        = $clog2(MAX_BYTES + 1)
);
  logic                   ll_enable;
  logic                   ll_start;
  logic                   ll_write;
  logic [6:0]             ll_dev;
  logic [7:0]             ll_reg;
  logic [7:0]             ll_wdata;
  logic [LW-1:0]          ll_len;
  logic                   ll_done;
  logic                   ll_nack;
  logic [MAX_BYTES*8-1:0] ll_rdata;

  // Sequencer side: issues commands, consumes completions.
  modport master (
    output ll_enable, ll_start, ll_write, ll_dev, ll_reg, ll_wdata, ll_len,
    input  ll_done, ll_nack, ll_rdata
  );

  // Engine side: consumes commands, reports completions.
  modport slave (
    input  ll_enable, ll_start, ll_write, ll_dev, ll_reg, ll_wdata, ll_len,
    output ll_done, ll_nack, ll_rdata
  );
endinterface

// File: rtl/i2c_poll_sequencer.sv
// Multi-channel I2C poll sequencer. On every poll tick it walks all channels, sending
// init writes to channels that still need them, then a pointer write and a burst read.
// Read bytes land in per-channel holding registers. NACKed commands are retried up to
// MAX_RETRY extra times; exhaustion faults the channel and forces a re-init next round.
module i2c_poll_sequencer #(
  parameter int NUM_CH    = 4,
  parameter int MAX_BYTES = 6,
  parameter int POLL_DIV  = 4000,
  parameter int MAX_RETRY = 2,
  localparam int LW = $clog2(MAX_BYTES + 1)
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             ch_en,
  input  logic [NUM_CH*7-1:0]           cfg_dev,
  input  logic [NUM_CH*32-1:0]          cfg_init,
  input  logic [NUM_CH*8-1:0]           cfg_rd_reg,
  input  logic [NUM_CH*LW-1:0]          cfg_rd_len,
  i2c_poll_sequencer_if.master          ll,
  output logic [NUM_CH*MAX_BYTES*8-1:0] rd_data,
  output logic [NUM_CH-1:0]             rd_valid,
  output logic [NUM_CH-1:0]             init_done,
  output logic [NUM_CH-1:0]             ch_fault,
  output logic                          poll_overrun,
  output logic                          busy,
  output logic [2:0]                    dbg_state
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW = $clog2(POLL_DIV);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEL   = 3'd1,
    S_INIT1 = 3'd2,
    S_INIT2 = 3'd3,
    S_PTR   = 3'd4,
    S_READ  = 3'd5,
    S_WAIT  = 3'd6,
    S_NEXT  = 3'd7
  } state_t;

  // Sequencer state and the command currently outstanding on the engine.
  state_t                          state_q, state_d;
  state_t                          cmd_q, cmd_d;
  logic [CW-1:0]                   ch_q, ch_d;
  logic [RW-1:0]                   retry_q, retry_d;
  logic [TW-1:0]                   tick_cnt_q, tick_cnt_d;

  // Registered engine command fields, held stable while the command is outstanding.
  logic                            start_q, start_d;
  logic                            write_q, write_d;
  logic [6:0]                      dev_q, dev_d;
  logic [7:0]                      reg_q, reg_d;
  logic [7:0]                      wdata_q, wdata_d;
  logic [LW-1:0]                   len_q, len_d;

  // Per-channel results and status.
  logic [NUM_CH*MAX_BYTES*8-1:0]   rd_data_q, rd_data_d;
  logic [NUM_CH-1:0]               rd_valid_q, rd_valid_d;
  logic [NUM_CH-1:0]               init_done_q, init_done_d;
  logic [NUM_CH-1:0]               fault_q, fault_d;
  logic                            overrun_q, overrun_d;

  logic                            tick;
  logic [6:0]                      cur_dev;
  logic [31:0]                     cur_init;
  logic [7:0]                      cur_rd_reg;
  logic [LW-1:0]                   cur_rd_len;

  assign tick = (tick_cnt_q == TW'(POLL_DIV - 1));

  // Select the configuration slice of the channel being served.
  always_comb begin
    cur_dev    = cfg_dev[int'(ch_q)*7 +: 7];
    cur_init   = cfg_init[int'(ch_q)*32 +: 32];
    cur_rd_reg = cfg_rd_reg[int'(ch_q)*8 +: 8];
    cur_rd_len = cfg_rd_len[int'(ch_q)*LW +: LW];
  end

  // Next-state logic: tick counter, channel walk, command issue, retry and capture.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    ch_d        = ch_q;
    retry_d     = retry_q;
    start_d     = 1'b0;
    write_d     = write_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    len_d       = len_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = '0;
    init_done_d = init_done_q;
    fault_d     = fault_q;
    tick_cnt_d  = tick ? '0 : tick_cnt_q + TW'(1);
    // A tick that finds the sequencer busy is dropped and only recorded.
    overrun_d   = overrun_q | (tick && (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          ch_d    = '0;
          state_d = S_SEL;
        end
      end

      S_SEL: begin
        retry_d = '0;
        if (!ch_en[ch_q]) begin
          state_d = S_NEXT;
        end else if (!init_done_q[ch_q]) begin
          state_d = S_INIT1;
        end else begin
          state_d = S_PTR;
        end
      end

      // Command states last one cycle: latch the fields from cfg_* and fire ll_start.
      S_INIT1, S_INIT2, S_PTR, S_READ: begin
        cmd_d   = state_q;
        start_d = 1'b1;
        dev_d   = cur_dev;
        state_d = S_WAIT;
        case (state_q)
          S_INIT1: begin
            write_d = 1'b1;
            reg_d   = cur_init[31:24];
            wdata_d = cur_init[23:16];
            len_d   = LW'(1);
          end
          S_INIT2: begin
            write_d = 1'b1;
            reg_d   = cur_init[15:8];
            wdata_d = cur_init[7:0];
            len_d   = LW'(1);
          end
          S_PTR: begin
            write_d = 1'b1;
            reg_d   = cur_rd_reg;
            wdata_d = 8'h00;
            len_d   = '0;
          end
          default: begin
            write_d = 1'b0;
            reg_d   = cur_rd_reg;
            wdata_d = 8'h00;
            len_d   = cur_rd_len;
          end
        endcase
      end

      S_WAIT: begin
        if (ll.ll_done) begin
          if (ll.ll_nack) begin
            if (int'(retry_q) < MAX_RETRY) begin
              retry_d = retry_q + RW'(1);
              state_d = cmd_q;
            end else begin
              fault_d[ch_q]     = 1'b1;
              init_done_d[ch_q] = 1'b0;
              state_d           = S_NEXT;
            end
          end else begin
            retry_d = '0;
            case (cmd_q)
              S_INIT1: state_d = S_INIT2;
              S_INIT2: begin
                init_done_d[ch_q] = 1'b1;
                state_d           = S_PTR;
              end
              S_PTR: state_d = (cur_rd_len == '0) ? S_NEXT : S_READ;
              S_READ: begin
                // Only the bytes actually read are replaced; the rest keep old values.
                for (int b = 0; b < MAX_BYTES; b++) begin
                  if (b < int'(len_q)) begin
                    rd_data_d[(int'(ch_q)*MAX_BYTES + b)*8 +: 8] = ll.ll_rdata[b*8 +: 8];
                  end
                end
                rd_valid_d[ch_q] = 1'b1;
                state_d          = S_NEXT;
              end
              default: state_d = S_NEXT;
            endcase
          end
        end
      end

      S_NEXT: begin
        if (ch_q == CW'(NUM_CH - 1)) begin
          state_d = S_IDLE;
        end else begin
          ch_d    = ch_q + CW'(1);
          state_d = S_SEL;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset; reset aborts any transfer.
  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= S_IDLE;
      ch_q        <= '0;
      retry_q     <= '0;
      tick_cnt_q  <= '0;
      start_q     <= 1'b0;
      write_q     <= 1'b0;
      dev_q       <= '0;
      reg_q       <= '0;
      wdata_q     <= '0;
      len_q       <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= '0;
      init_done_q <= '0;
      fault_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      ch_q        <= ch_d;
      retry_q     <= retry_d;
      tick_cnt_q  <= tick_cnt_d;
      start_q     <= start_d;
      write_q     <= write_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      len_q       <= len_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      init_done_q <= init_done_d;
      fault_q     <= fault_d;
      overrun_q   <= overrun_d;
    end
  end

  // Engine enable follows the state register so it drops right after a reset edge.
  assign ll.ll_enable = (state_q != S_IDLE);
  assign ll.ll_start  = start_q;
  assign ll.ll_write  = write_q;
  assign ll.ll_dev    = dev_q;
  assign ll.ll_reg    = reg_q;
  assign ll.ll_wdata  = wdata_q;
  assign ll.ll_len    = len_q;

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign init_done    = init_done_q;
  assign ch_fault     = fault_q;
  assign poll_overrun = overrun_q;
  assign busy         = (state_q != S_IDLE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_i2c_poll_sequencer.sv
// Bench for i2c_poll_sequencer: two channels, short poll period, a behavioural engine
// that answers commands with configurable latency, NACKs and read data.
module tb_i2c_poll_sequencer;
  localparam int NC = 2;
  localparam int MB = 6;
  localparam int PD = 100;
  localparam int MR = 2;
  localparam int LW = 3;

  localparam logic [6:0]  DEV0  = 7'h52;
  localparam logic [6:0]  DEV1  = 7'h1A;
  localparam logic [31:0] INIT0 = 32'hF055_FB00;
  localparam logic [31:0] INIT1 = 32'h4001_4102;

  // Clock and reset
  logic clock = 1'b0;
  logic rst   = 1'b0;
  always #5 clock = ~clock;

  logic [NC-1:0]      ch_en;
  logic [NC*7-1:0]    cfg_dev;
  logic [NC*32-1:0]   cfg_init;
  logic [NC*8-1:0]    cfg_rd_reg;
  logic [NC*LW-1:0]   cfg_rd_len;
  logic [NC*MB*8-1:0] rd_data;
  logic [NC-1:0]      rd_valid;
  logic [NC-1:0]      init_done;
  logic [NC-1:0]      ch_fault;
  logic               poll_overrun;
  logic               busy;
  logic [2:0]         dbg_state;

  i2c_poll_sequencer_if #(.MAX_BYTES(MB)) ll_if ();

  i2c_poll_sequencer #(
    .NUM_CH(NC), .MAX_BYTES(MB), .POLL_DIV(PD), .MAX_RETRY(MR)
  ) dut (
    .clock(clock), .rst(rst), .ch_en(ch_en), .cfg_dev(cfg_dev), .cfg_init(cfg_init),
    .cfg_rd_reg(cfg_rd_reg), .cfg_rd_len(cfg_rd_len), .ll(ll_if), .rd_data(rd_data),
    .rd_valid(rd_valid), .init_done(init_done), .ch_fault(ch_fault),
    .poll_overrun(poll_overrun), .busy(busy), .dbg_state(dbg_state)
  );

  // Scoreboard state
  int n_checks = 0;
  int n_pass   = 0;
  logic [26:0] exp_cmd_q[$];
  logic [49:0] exp_rd_q[$];

  // Engine model state
  logic [47:0] vec0, vec1;
  int          eng_cnt    = 0;
  int          nack_left  = 0;
  bit          stall_next = 1'b0;
  logic [6:0]  eng_dev    = '0;
  logic        eng_write  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Command word; wdata only matters for data-carrying writes.
  function automatic logic [26:0] cmd_w(input logic w, input logic [6:0] d, input logic [7:0] r,
                                        input logic [7:0] wd, input logic [2:0] len);
    return {w, d, r, (w && len != 3'd0) ? wd : 8'h00, len};
  endfunction

  task automatic exp_init(input logic [6:0] d, input logic [31:0] iv);
    exp_cmd_q.push_back(cmd_w(1'b1, d, iv[31:24], iv[23:16], 3'd1));
    exp_cmd_q.push_back(cmd_w(1'b1, d, iv[15:8], iv[7:0], 3'd1));
  endtask

  task automatic exp_poll(input logic [6:0] d, input logic [7:0] r, input logic [2:0] len);
    exp_cmd_q.push_back(cmd_w(1'b1, d, r, 8'h00, 3'd0));
    exp_cmd_q.push_back(cmd_w(1'b0, d, r, 8'h00, len));
  endtask

  // Waits for a round to start on a tick and to finish, both bounded.
  task automatic wait_round(input string tag);
    int n;
    n = 0;
    while (!busy && n < 300) begin @(negedge clock); n++; end
    chk({tag, "_start"}, busy, 1);
    n = 0;
    while (busy && n < 500) begin @(negedge clock); n++; end
    chk({tag, "_end"}, busy, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ll_enable"}, ll_if.ll_enable, 0);
    chk({tag, "_ll_start"}, ll_if.ll_start, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_init_done"}, init_done, 0);
    chk({tag, "_ch_fault"}, ch_fault, 0);
    chk({tag, "_overrun"}, poll_overrun, 0);
    chk({tag, "_rd_data0"}, rd_data[47:0], 0);
    chk({tag, "_rd_data1"}, rd_data[95:48], 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  // Engine model: latches a command on ll_start, answers after a latency.
  initial begin
    ll_if.ll_done  = 1'b0;
    ll_if.ll_nack  = 1'b0;
    ll_if.ll_rdata = '0;
    forever begin
      @(negedge clock);
      ll_if.ll_done = 1'b0;
      ll_if.ll_nack = 1'b0;
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          ll_if.ll_done  = 1'b1;
          ll_if.ll_rdata = (eng_dev == DEV0) ? vec0 : vec1;
          if (!eng_write && eng_dev == DEV1 && nack_left > 0) begin
            ll_if.ll_nack = 1'b1;
            nack_left--;
          end
        end
      end else if (ll_if.ll_start) begin
        eng_dev    = ll_if.ll_dev;
        eng_write  = ll_if.ll_write;
        eng_cnt    = stall_next ? 150 : 3;
        stall_next = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever a command or a read update is presented.
  logic [26:0] mon_cmd;
  logic [49:0] mon_rd;
  always @(negedge clock) begin
    if (rst) begin
      if (ll_if.ll_start) begin
        mon_cmd = cmd_w(ll_if.ll_write, ll_if.ll_dev, ll_if.ll_reg, ll_if.ll_wdata, ll_if.ll_len);
        chk("cmd_expected_present", exp_cmd_q.size() != 0, 1);
        if (exp_cmd_q.size() != 0) chk("cmd", mon_cmd, exp_cmd_q.pop_front());
      end
      if (rd_valid != '0) begin
        mon_rd = {rd_valid, rd_valid[1] ? rd_data[95:48] : rd_data[47:0]};
        chk("rd_expected_present", exp_rd_q.size() != 0, 1);
        if (exp_rd_q.size() != 0) chk("rd_update", mon_rd, exp_rd_q.pop_front());
      end
    end
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int n;
    ch_en      = 2'b11;
    cfg_dev    = {DEV1, DEV0};
    cfg_init   = {INIT1, INIT0};
    cfg_rd_reg = {8'h10, 8'h00};
    cfg_rd_len = {3'd6, 3'd6};
    vec0       = 48'h0605_0403_0201;
    vec1       = 48'h1615_1413_1211;
    rst        = 1'b0;
    repeat (3) @(negedge clock);
    check_zero("reset");
    rst = 1'b1;

    // 1: first round initialises and reads both channels
    exp_init(DEV0, INIT0); exp_poll(DEV0, 8'h00, 3'd6);
    exp_init(DEV1, INIT1); exp_poll(DEV1, 8'h10, 3'd6);
    exp_rd_q.push_back({2'b01, 48'h0605_0403_0201});
    exp_rd_q.push_back({2'b10, 48'h1615_1413_1211});
    wait_round("t1");
    chk("t1_init_done", init_done, 2'b11);
    chk("t1_fault", ch_fault, 2'b00);

    // 2: second round skips init
    vec0 = 48'hA5A4_A3A2_A1A0;
    vec1 = 48'hB5B4_B3B2_B1B0;
    exp_poll(DEV0, 8'h00, 3'd6); exp_poll(DEV1, 8'h10, 3'd6);
    exp_rd_q.push_back({2'b01, 48'hA5A4_A3A2_A1A0});
    exp_rd_q.push_back({2'b10, 48'hB5B4_B3B2_B1B0});
    wait_round("t2");
    chk("t2_rd_data0", rd_data[47:0], 48'hA5A4_A3A2_A1A0);
    chk("t2_rd_data1", rd_data[95:48], 48'hB5B4_B3B2_B1B0);
    chk("t2_cmd_q_empty", exp_cmd_q.size(), 0);

    // 3: reset, then only channel 1 enabled; partial read keeps upper bytes
    rst = 1'b0;
    @(negedge clock);
    rst = 1'b1;
    ch_en = 2'b10;
    vec1  = 48'hC5C4_C3C2_C1C0;
    exp_init(DEV1, INIT1); exp_poll(DEV1, 8'h10, 3'd6);
    exp_rd_q.push_back({2'b10, 48'hC5C4_C3C2_C1C0});
    wait_round("t3a");
    chk("t3a_init_done", init_done, 2'b10);
    cfg_rd_len = {3'd3, 3'd6};
    vec1 = 48'hD5D4_D3D2_D1D0;
    exp_poll(DEV1, 8'h10, 3'd3);
    exp_rd_q.push_back({2'b10, 48'hC5C4_C3D2_D1D0});
    wait_round("t3b");
    chk("t3_ch0_zero", rd_data[47:0], 48'h0);
    chk("t3_rd_data1", rd_data[95:48], 48'hC5C4_C3D2_D1D0);

    // 4: channel 1 NACKs every READ attempt until faulted, then re-inits
    ch_en      = 2'b11;
    cfg_rd_len = {3'd6, 3'd6};
    nack_left  = 3;
    vec0 = 48'hE5E4_E3E2_E1E0;
    vec1 = 48'h3534_3332_3130;
    exp_init(DEV0, INIT0); exp_poll(DEV0, 8'h00, 3'd6);
    exp_cmd_q.push_back(cmd_w(1'b1, DEV1, 8'h10, 8'h00, 3'd0));
    repeat (3) exp_cmd_q.push_back(cmd_w(1'b0, DEV1, 8'h10, 8'h00, 3'd6));
    exp_rd_q.push_back({2'b01, 48'hE5E4_E3E2_E1E0});
    wait_round("t4a");
    chk("t4a_fault", ch_fault, 2'b10);
    chk("t4a_init_done", init_done, 2'b01);
    chk("t4a_rd_data1_kept", rd_data[95:48], 48'hC5C4_C3D2_D1D0);
    vec0 = 48'hF5F4_F3F2_F1F0;
    vec1 = 48'h2524_2322_2120;
    exp_poll(DEV0, 8'h00, 3'd6);
    exp_init(DEV1, INIT1); exp_poll(DEV1, 8'h10, 3'd6);
    exp_rd_q.push_back({2'b01, 48'hF5F4_F3F2_F1F0});
    exp_rd_q.push_back({2'b10, 48'h2524_2322_2120});
    wait_round("t4b");
    chk("t4b_init_done", init_done, 2'b11);
    chk("t4b_fault_sticky", ch_fault, 2'b10);

    // 5: engine stalls past a tick; overrun set, no extra round mid-transfer
    chk("t5_overrun_before", poll_overrun, 0);
    stall_next = 1'b1;
    vec0 = 48'h4544_4342_4140;
    vec1 = 48'h5554_5352_5150;
    exp_poll(DEV0, 8'h00, 3'd6); exp_poll(DEV1, 8'h10, 3'd6);
    exp_rd_q.push_back({2'b01, 48'h4544_4342_4140});
    exp_rd_q.push_back({2'b10, 48'h5554_5352_5150});
    wait_round("t5");
    chk("t5_overrun", poll_overrun, 1);
    chk("t5_cmd_q_empty", exp_cmd_q.size(), 0);
    chk("t5_rd_q_empty", exp_rd_q.size(), 0);

    // 6: reset while channel 0 READ is outstanding; late ll_done ignored
    exp_poll(DEV0, 8'h00, 3'd6);
    n = 0;
    while (!(ll_if.ll_start && !ll_if.ll_write) && n < 300) begin @(negedge clock); n++; end
    chk("t6_read_seen", ll_if.ll_start && !ll_if.ll_write, 1);
    rst = 1'b0;
    exp_cmd_q.delete();
    exp_rd_q.delete();
    @(negedge clock);
    check_zero("t6");
    rst = 1'b1;
    repeat (10) @(negedge clock);
    chk("t6_late_busy", busy, 0);
    chk("t6_late_rd_data0", rd_data[47:0], 48'h0);
    chk("t6_late_init_done", init_done, 2'b00);
    chk("t6_late_state", dbg_state, 0);
    chk("end_cmd_q_empty", exp_cmd_q.size(), 0);
    chk("end_rd_q_empty", exp_rd_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
